// File: rtl/muldiv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_seq_ctrl
// Iterative RV32M multiply/divide sequencer that sits beside the EX stage.
// One M-extension op is accepted from EX. It runs a 32-iteration shift-add
// multiply or a restoring divide on shared datapath registers. The pipeline is
// stalled while the op runs, and the result is then presented for one cycle.
//
// Optional feature macro: MULDIV_EARLY_EN
//   When it is defined, a zero-operand op finishes directly IDLE->DONE.
//   MUL* finishes this way when rs1 or rs2 is zero, and DIV*/REM* when rs2 is
//   zero. done_o then rises one cycle after accept.
//   When it is not defined, every op takes the full 32 CALC cycles.
//
// Parameters:
//   XLEN  - operand/result width (only 32 supported)
//   CNT_W - iteration counter width, 2**CNT_W == XLEN
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start_i  in   EX presents a valid M-op this cycle
//   op_i     in   funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_i    in   operand A
//   rs2_i    in   operand B
//   rd_i     in   destination register
//   flush_i  in   abort the current op
//   stall_o  out  pipeline stall request (combinational)
//   busy_o   out  FSM not in IDLE
//   done_o   out  one-cycle result-valid pulse
//   result_o out  final result, valid with done_o
//   rd_o     out  destination register latched at accept
// -----------------------------------------------------------------------------
module muldiv_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ZERO_X = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES_X = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement magnitude when the operand is treated as negative
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + ONE_X) : v;
  endfunction

  state_t            state_r, state_nxt;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        op_r;
  logic [4:0]        rd_r;
  logic              s1_r, s2_r, bz_r;
  // hi_r: product high half / partial remainder; lo_r: multiplier / quotient
  logic [XLEN-1:0]   hi_r, lo_r, b_r;
  logic [XLEN-1:0]   result_r;

  logic              accept_s;
  logic              sa_s, sb_s, s1_s, s2_s;
  logic              early_zero_s;
  logic [XLEN-1:0]   early_res_s;
  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] acc_s;
  logic [XLEN:0]     shifted_s;
  logic [XLEN-1:0]   sub_s;
  logic              ge_s;
  logic [XLEN-1:0]   hi_nxt, lo_nxt;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   final_s;

  assign accept_s = (state_r == IDLE) && start_i && !flush_i;

  // Operand sign treatment decoded from funct3 at accept
  always_comb begin
    sa_s = 1'b0;
    sb_s = 1'b0;
    case (op_i)
      3'b001, 3'b100, 3'b110: begin sa_s = 1'b1; sb_s = 1'b1; end
      3'b010:                 begin sa_s = 1'b1; sb_s = 1'b0; end
      default:                begin sa_s = 1'b0; sb_s = 1'b0; end
    endcase
  end

  assign s1_s = sa_s && rs1_i[XLEN-1];
  assign s2_s = sb_s && rs2_i[XLEN-1];

  // Zero-operand shortcut decision and its architectural result
  always_comb begin
`ifdef MULDIV_EARLY_EN
    if (op_i[2]) begin
      early_zero_s = (rs2_i == ZERO_X);
      early_res_s  = op_i[1] ? rs1_i : ONES_X;
    end else begin
      early_zero_s = (rs1_i == ZERO_X) || (rs2_i == ZERO_X);
      early_res_s  = ZERO_X;
    end
`else
    early_zero_s = 1'b0;
    early_res_s  = ZERO_X;
`endif
  end

  // One multiply or restoring-divide iteration on the shared registers
  always_comb begin
    mul_sum_s = {1'b0, hi_r} + {1'b0, b_r};
    acc_s     = lo_r[0] ? {mul_sum_s, lo_r[XLEN-1:1]} : {1'b0, hi_r, lo_r[XLEN-1:1]};
    shifted_s = {hi_r, lo_r[XLEN-1]};
    ge_s      = (shifted_s >= {1'b0, b_r});
    sub_s     = shifted_s[XLEN-1:0] - b_r;
    if (op_r[2]) begin
      hi_nxt = ge_s ? sub_s : shifted_s[XLEN-1:0];
      lo_nxt = {lo_r[XLEN-2:0], ge_s};
    end else begin
      hi_nxt = acc_s[2*XLEN-1:XLEN];
      lo_nxt = acc_s[XLEN-1:0];
    end
  end

  // Sign fix-up and result selection from the final iteration's values
  always_comb begin
    prod_s = {hi_nxt, lo_nxt};
    if (s1_r ^ s2_r) begin
      prod_s = ~prod_s + ONE_2X;
    end else begin
      prod_s = {hi_nxt, lo_nxt};
    end
    if (op_r[2]) begin
      if (op_r[1]) begin
        final_s = s1_r ? (~hi_nxt + ONE_X) : hi_nxt;
      end else if (bz_r) begin
        // Divide by zero yields all ones whatever the operand signs
        final_s = ONES_X;
      end else begin
        final_s = (s1_r ^ s2_r) ? (~lo_nxt + ONE_X) : lo_nxt;
      end
    end else begin
      final_s = (op_r[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic; flush returns to IDLE from any state
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt = early_zero_s ? DONE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt = DONE;
        end else begin
          state_nxt = CALC;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, operand latches, datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      op_r     <= 3'b000;
      rd_r     <= 5'd0;
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      bz_r     <= 1'b0;
      hi_r     <= ZERO_X;
      lo_r     <= ZERO_X;
      b_r      <= ZERO_X;
      result_r <= ZERO_X;
    end else begin
      state_r <= state_nxt;
      if (accept_s) begin
        op_r  <= op_i;
        rd_r  <= rd_i;
        s1_r  <= s1_s;
        s2_r  <= s2_s;
        bz_r  <= (rs2_i == ZERO_X);
        hi_r  <= ZERO_X;
        lo_r  <= mag(rs1_i, s1_s);
        b_r   <= mag(rs2_i, s2_s);
        cnt_r <= {CNT_W{1'b1}};
        if (early_zero_s) begin
          result_r <= early_res_s;
        end
      end else if ((state_r == CALC) && !flush_i) begin
        hi_r  <= hi_nxt;
        lo_r  <= lo_nxt;
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r == {CNT_W{1'b0}}) begin
          result_r <= final_s;
        end
      end
    end
  end

  // The accepting cycle must stall too, so stall_o is not registered
  assign stall_o  = accept_s || (state_r == CALC);
  assign busy_o   = (state_r != IDLE);
  assign done_o   = (state_r == DONE) && !flush_i;
  assign result_o = result_r;
  assign rd_o     = rd_r;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq_ctrl
// Directed self-checking bench for muldiv_seq_ctrl. Expected values are hand
// computed. Inputs are driven 1 time unit after the rising edge, and outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_muldiv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_EARLY_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  always #5 clk = ~clk;

  muldiv_seq_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .rd_o(rd_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at cycle 0 and follow it to done_o
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int lat_exp);
    int lat;
    int stalls;
    logic [31:0] res;
    logic [4:0]  rdv;
    lat = 0; stalls = 0; res = 32'd0; rdv = 5'd0;
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
    @(negedge clk);
    chk({tag, "_stall_c0"}, 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0; rs1_i = 32'd0; rs2_i = 32'd0; rd_i = 5'd0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done_o) begin
        lat = c; res = result_o; rdv = rd_o;
        break;
      end
      if (stall_o) stalls++;
      @(posedge clk); #1;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(lat_exp - 1));
    chk({tag, "_result"}, res, exp);
    chk({tag, "_rd"}, 32'(rdv), 32'(rd));
    chk({tag, "_stall_at_done"}, 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, 32'(done_o), 32'd0);
    chk({tag, "_idle_after"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int saw_done;
    rst_n = 1'b0; start_i = 1'b0; op_i = 3'b000; rs1_i = 32'd0; rs2_i = 32'd0;
    rd_i = 5'd0; flush_i = 1'b0;
    #12;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_o), 32'd0);
    rst_n = 1'b1;

    do_op("mul_7x6",       3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       33);
    do_op("mulh_m1x2",     3'b001, 32'hFFFFFFFF, 32'h00000002, 5'd6,  32'hFFFFFFFF, 33);
    do_op("mulhu_m1x2",    3'b011, 32'hFFFFFFFF, 32'h00000002, 5'd7,  32'h00000001, 33);
    do_op("mulhsu_m1x2",   3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'hFFFFFFFF, 33);
    do_op("mul_big",       3'b000, 32'h0000FFFF, 32'h00010001, 5'd9,  32'hFFFFFFFF, 33);
    do_op("div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33);
    do_op("rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33);
    do_op("div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 33);
    do_op("divu_5_0",      3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, ZLAT);
    do_op("remu_5_0",      3'b111, 32'd5,        32'd0,        5'd14, 32'd5,        ZLAT);
    do_op("div_m5_0",      3'b100, 32'hFFFFFFFB, 32'd0,        5'd15, 32'hFFFFFFFF, ZLAT);
    do_op("rem_m5_0",      3'b110, 32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFB, ZLAT);
    do_op("mul_x_0",       3'b000, 32'd123,      32'd0,        5'd17, 32'd0,        ZLAT);

    // Flush a DIVU 100/3 at cycle 10
    saw_done = 0;
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd3; rd_i = 5'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (done_o) saw_done = 1;
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stall_c10", 32'(stall_o), 32'd1);
    chk("flush_done_c10", 32'(done_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_busy_c11", 32'(busy_o), 32'd0);
    chk("flush_stall_c11", 32'(stall_o), 32'd0);
    chk("flush_done_c11", 32'(done_o), 32'd0);
    chk("flush_no_done_before", 32'(saw_done), 32'd0);
    do_op("divu_100_3", 3'b101, 32'd100, 32'd3, 5'd9, 32'd33, 33);

    // Asynchronous reset in the middle of a MUL
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'b000; rs1_i = 32'd3; rs2_i = 32'd4; rd_i = 5'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 32'(stall_o), 32'd0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_done", 32'(done_o), 32'd0);
    chk("async_rst_result", result_o, 32'd0);
    chk("async_rst_rd", 32'(rd_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // start_i and flush_i together in IDLE: flush wins
    @(posedge clk); #1;
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'b000; rs1_i = 32'd2; rs2_i = 32'd2;
    @(negedge clk);
    chk("startflush_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("startflush_busy", 32'(busy_o), 32'd0);

    do_op("mul_after_rst", 3'b000, 32'd9, 32'd9, 5'd3, 32'd81, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
